// File: rtl/vga_timing_config_regs_if.sv
// Configuration write bus between a bus master and the VGA timing register block.
interface vga_timing_config_regs_if #(
   parameter int CONFIG_WIDTH = 16
) ();
   logic                    Valid;
   logic [CONFIG_WIDTH-1:0] Addr;
   logic [CONFIG_WIDTH-1:0] Data;
   logic                    Ready;
   logic                    Err;

   modport master (output Valid, Addr, Data, input Ready, Err);
   modport slave  (input Valid, Addr, Data, output Ready, Err);
endinterface

// File: rtl/vga_timing_config_regs.sv
// VGA timing configuration registers: holds the active timing set (three 60 Hz
// presets or a custom mode built from shadow registers) and hands new modes to
// the counters with a one-cycle Load_config strobe, either immediately or at
// the next frame boundary.
module vga_timing_config_regs #(
   parameter int                    CONFIG_WIDTH   = 16,
   parameter logic [CONFIG_WIDTH-1:0] ADDR_BASE    = 16'h0010,
   parameter int                    REZ_MAX_WIDTH  = 11,
   parameter int                    PULSE_WIDTH    = 8,
   parameter int                    MARGIN_WIDTH   = 8,
   parameter int                    APPLY_AT_FRAME = 1
) (
   input  logic                     Clk,
   input  logic                     rst_n,
   vga_timing_config_regs_if.slave  cfg,
   input  logic                     Frame_end,
   output logic                     Load_config,
   output logic [1:0]               Mode,
   output logic [REZ_MAX_WIDTH-1:0] H_count_max,
   output logic [REZ_MAX_WIDTH-1:0] V_count_max,
   output logic [PULSE_WIDTH-1:0]   H_sync_pulse,
   output logic [PULSE_WIDTH-1:0]   V_sync_pulse,
   output logic [MARGIN_WIDTH-1:0]  H_left_margin,
   output logic [MARGIN_WIDTH-1:0]  H_right_margin,
   output logic [MARGIN_WIDTH-1:0]  V_left_margin,
   output logic [MARGIN_WIDTH-1:0]  V_right_margin
);

   localparam int SUM_W = REZ_MAX_WIDTH + 2;

   typedef struct packed {
      logic [REZ_MAX_WIDTH-1:0] hmax;
      logic [REZ_MAX_WIDTH-1:0] vmax;
      logic [PULSE_WIDTH-1:0]   hsync;
      logic [PULSE_WIDTH-1:0]   vsync;
      logic [MARGIN_WIDTH-1:0]  hleft;
      logic [MARGIN_WIDTH-1:0]  hright;
      logic [MARGIN_WIDTH-1:0]  vleft;
      logic [MARGIN_WIDTH-1:0]  vright;
   } timing_t;

   typedef enum logic {IDLE, PENDING} state_t;

   // Built-in 60 Hz timing sets; anything other than 1 or 2 maps to 640x480.
   function automatic timing_t preset(input logic [1:0] m);
      timing_t t;
      case (m)
         2'd1: begin
            t.hmax = REZ_MAX_WIDTH'(1056); t.hsync = PULSE_WIDTH'(128);
            t.hleft = MARGIN_WIDTH'(88);   t.hright = MARGIN_WIDTH'(40);
            t.vmax = REZ_MAX_WIDTH'(628);  t.vsync = PULSE_WIDTH'(4);
            t.vleft = MARGIN_WIDTH'(23);   t.vright = MARGIN_WIDTH'(1);
         end
         2'd2: begin
            t.hmax = REZ_MAX_WIDTH'(1344); t.hsync = PULSE_WIDTH'(136);
            t.hleft = MARGIN_WIDTH'(160);  t.hright = MARGIN_WIDTH'(24);
            t.vmax = REZ_MAX_WIDTH'(806);  t.vsync = PULSE_WIDTH'(6);
            t.vleft = MARGIN_WIDTH'(29);   t.vright = MARGIN_WIDTH'(3);
         end
         default: begin
            t.hmax = REZ_MAX_WIDTH'(800);  t.hsync = PULSE_WIDTH'(96);
            t.hleft = MARGIN_WIDTH'(48);   t.hright = MARGIN_WIDTH'(16);
            t.vmax = REZ_MAX_WIDTH'(525);  t.vsync = PULSE_WIDTH'(2);
            t.vleft = MARGIN_WIDTH'(33);   t.vright = MARGIN_WIDTH'(10);
         end
      endcase
      return t;
   endfunction

   // A custom set is usable only if each total leaves room for a visible area.
   // Sums are two bits wider than the totals so three fields cannot wrap.
   function automatic logic timing_valid(input timing_t t);
      logic [SUM_W-1:0] hsum;
      logic [SUM_W-1:0] vsum;
      hsum = SUM_W'(t.hsync) + SUM_W'(t.hleft) + SUM_W'(t.hright);
      vsum = SUM_W'(t.vsync) + SUM_W'(t.vleft) + SUM_W'(t.vright);
      return (SUM_W'(t.hmax) > hsum) && (SUM_W'(t.vmax) > vsum);
   endfunction

   state_t                  state, state_nxt;
   timing_t                 active, shadow, target;
   logic [1:0]              mode_q, tgt_mode;
   logic                    load_q, err_q;
   logic                    ready;
   logic                    accept, mode_wr, mode_ok;
   logic                    err_set, capture, apply_sel, apply_tgt;
   logic [CONFIG_WIDTH-1:0] offset;
   timing_t                 sel_timing;
   logic [1:0]              sel_mode;

   assign offset     = cfg.Addr - ADDR_BASE;
   assign accept     = cfg.Valid && ready;
   assign mode_wr    = accept && (offset == '0);
   assign sel_mode   = cfg.Data[1:0];
   assign sel_timing = (sel_mode == 2'd3) ? shadow : preset(sel_mode);
   assign mode_ok    = (cfg.Data < CONFIG_WIDTH'(3)) ||
                       ((cfg.Data == CONFIG_WIDTH'(3)) && timing_valid(shadow));

   // Mode-change control: decide between reject, immediate apply, deferral, frame apply.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      err_set   = 1'b0;
      capture   = 1'b0;
      apply_sel = 1'b0;
      apply_tgt = 1'b0;
      unique case (state)
         IDLE: begin
            ready = !load_q;
            if (mode_wr) begin
               if (!mode_ok) begin
                  err_set = 1'b1;
               end else if (APPLY_AT_FRAME != 0) begin
                  capture   = 1'b1;
                  state_nxt = PENDING;
               end else begin
                  apply_sel = 1'b1;
               end
            end
         end
         PENDING: begin
            if (Frame_end) begin
               apply_tgt = 1'b1;
               state_nxt = IDLE;
            end
         end
      endcase
   end

   // State, active timing set and the one-cycle strobes.
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         active <= preset(2'd0);
         mode_q <= 2'd0;
         load_q <= 1'b1;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         load_q <= apply_sel || apply_tgt;
         err_q  <= err_set;
         if (apply_sel) begin
            active <= sel_timing;
            mode_q <= sel_mode;
         end else if (apply_tgt) begin
            active <= target;
            mode_q <= tgt_mode;
         end
      end
   end

   // Shadow registers: field writes at offsets 1-8, truncated to field width.
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= preset(2'd0);
      end else if (accept) begin
         case (offset)
            CONFIG_WIDTH'(1): shadow.hmax   <= REZ_MAX_WIDTH'(cfg.Data);
            CONFIG_WIDTH'(2): shadow.vmax   <= REZ_MAX_WIDTH'(cfg.Data);
            CONFIG_WIDTH'(3): shadow.hsync  <= PULSE_WIDTH'(cfg.Data);
            CONFIG_WIDTH'(4): shadow.vsync  <= PULSE_WIDTH'(cfg.Data);
            CONFIG_WIDTH'(5): shadow.hleft  <= MARGIN_WIDTH'(cfg.Data);
            CONFIG_WIDTH'(6): shadow.hright <= MARGIN_WIDTH'(cfg.Data);
            CONFIG_WIDTH'(7): shadow.vleft  <= MARGIN_WIDTH'(cfg.Data);
            CONFIG_WIDTH'(8): shadow.vright <= MARGIN_WIDTH'(cfg.Data);
            default: ;
         endcase
      end
   end

   // Pending target: snapshot taken at acceptance so later shadow writes cannot leak in.
   always_ff @(posedge Clk) begin
      if (capture) begin
         target   <= sel_timing;
         tgt_mode <= sel_mode;
      end
   end

   assign cfg.Ready      = ready;
   assign cfg.Err        = err_q;
   assign Load_config    = load_q;
   assign Mode           = mode_q;
   assign H_count_max    = active.hmax;
   assign V_count_max    = active.vmax;
   assign H_sync_pulse   = active.hsync;
   assign V_sync_pulse   = active.vsync;
   assign H_left_margin  = active.hleft;
   assign H_right_margin = active.hright;
   assign V_left_margin  = active.vleft;
   assign V_right_margin = active.vright;

endmodule

// File: tb/tb_vga_timing_config_regs.sv
// Bench for vga_timing_config_regs: one instance applying immediately (d0) and
// one applying at frame end (d1), compared every cycle against a rule-level model.
module tb_vga_timing_config_regs;

   logic        Clk = 1'b0;
   logic        rst_n;
   logic        valid_i [2];
   logic [15:0] addr_i  [2];
   logic [15:0] data_i  [2];
   logic        fe_i    [2];
   logic        ready_o [2];
   logic        err_o   [2];
   logic        load_o  [2];
   logic [1:0]  mode_o  [2];
   logic [10:0] hmax_o  [2];
   logic [10:0] vmax_o  [2];
   logic [7:0]  hsync_o [2];
   logic [7:0]  vsync_o [2];
   logic [7:0]  hl_o    [2];
   logic [7:0]  hr_o    [2];
   logic [7:0]  vl_o    [2];
   logic [7:0]  vr_o    [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   vga_timing_config_regs_if #(.CONFIG_WIDTH(16)) if0 ();
   vga_timing_config_regs_if #(.CONFIG_WIDTH(16)) if1 ();

   assign if0.Valid = valid_i[0];
   assign if0.Addr  = addr_i[0];
   assign if0.Data  = data_i[0];
   assign if1.Valid = valid_i[1];
   assign if1.Addr  = addr_i[1];
   assign if1.Data  = data_i[1];
   assign ready_o[0] = if0.Ready;
   assign err_o[0]   = if0.Err;
   assign ready_o[1] = if1.Ready;
   assign err_o[1]   = if1.Err;

   vga_timing_config_regs #(.APPLY_AT_FRAME(0)) d0 (
      .Clk(Clk), .rst_n(rst_n), .cfg(if0), .Frame_end(fe_i[0]),
      .Load_config(load_o[0]), .Mode(mode_o[0]),
      .H_count_max(hmax_o[0]), .V_count_max(vmax_o[0]),
      .H_sync_pulse(hsync_o[0]), .V_sync_pulse(vsync_o[0]),
      .H_left_margin(hl_o[0]), .H_right_margin(hr_o[0]),
      .V_left_margin(vl_o[0]), .V_right_margin(vr_o[0]));

   vga_timing_config_regs #(.APPLY_AT_FRAME(1)) d1 (
      .Clk(Clk), .rst_n(rst_n), .cfg(if1), .Frame_end(fe_i[1]),
      .Load_config(load_o[1]), .Mode(mode_o[1]),
      .H_count_max(hmax_o[1]), .V_count_max(vmax_o[1]),
      .H_sync_pulse(hsync_o[1]), .V_sync_pulse(vsync_o[1]),
      .H_left_margin(hl_o[1]), .H_right_margin(hr_o[1]),
      .V_left_margin(vl_o[1]), .V_right_margin(vr_o[1]));

   // Reference model. Field index = register offset - 1:
   // 0 Hmax, 1 Vmax, 2 Hsync, 3 Vsync, 4 Hleft, 5 Hright, 6 Vleft, 7 Vright.
   int PRE [3][8] = '{'{800, 525, 96, 2, 48, 16, 33, 10},
                      '{1056, 628, 128, 4, 88, 40, 23, 1},
                      '{1344, 806, 136, 6, 160, 24, 29, 3}};
   int act [2][8];
   int shd [2][8];
   int tgt [2][8];
   int md  [2];
   int tmd [2];
   bit ld  [2];
   bit er  [2];
   bit pnd [2];

   function automatic int field_mask(input int i);
      return (i < 2) ? 2047 : 255;
   endfunction

   function automatic bit custom_ok(input int k);
      return (shd[k][0] > shd[k][2] + shd[k][4] + shd[k][5]) &&
             (shd[k][1] > shd[k][3] + shd[k][6] + shd[k][7]);
   endfunction

   task automatic model_reset(input int k);
      for (int i = 0; i < 8; i++) begin
         act[k][i] = PRE[0][i];
         shd[k][i] = PRE[0][i];
      end
      md[k] = 0; ld[k] = 1'b1; er[k] = 1'b0; pnd[k] = 1'b0;
   endtask

   // One clock edge of instance k; d1 (k==1) defers modes to the next Frame_end.
   task automatic model_step(input int k);
      bit acc, ldn, ern;
      int off, dv;
      if (!rst_n) begin
         model_reset(k);
         return;
      end
      acc = valid_i[k] && !pnd[k] && !ld[k];
      ldn = 1'b0; ern = 1'b0;
      if (pnd[k] && fe_i[k]) begin
         for (int i = 0; i < 8; i++) act[k][i] = tgt[k][i];
         md[k] = tmd[k]; ldn = 1'b1; pnd[k] = 1'b0;
      end
      if (acc) begin
         off = (int'(addr_i[k]) - 16) & 32'hFFFF;
         dv  = int'(data_i[k]);
         if (off == 0) begin
            if (dv < 3 || (dv == 3 && custom_ok(k))) begin
               for (int i = 0; i < 8; i++) begin
                  if (k == 1) tgt[k][i] = (dv < 3) ? PRE[dv][i] : shd[k][i];
                  else        act[k][i] = (dv < 3) ? PRE[dv][i] : shd[k][i];
               end
               if (k == 1) begin tmd[k] = dv; pnd[k] = 1'b1; end
               else begin md[k] = dv; ldn = 1'b1; end
            end else begin
               ern = 1'b1;
            end
         end else if (off >= 1 && off <= 8) begin
            shd[k][off-1] = dv & field_mask(off - 1);
         end
      end
      ld[k] = ldn; er[k] = ern;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("d%0d_ready", k), 32'(ready_o[k]), 32'(!pnd[k] && !ld[k]));
         chk($sformatf("d%0d_err", k),   32'(err_o[k]),   32'(er[k]));
         chk($sformatf("d%0d_load", k),  32'(load_o[k]),  32'(ld[k]));
         chk($sformatf("d%0d_mode", k),  32'(mode_o[k]),  md[k]);
         chk($sformatf("d%0d_hmax", k),  32'(hmax_o[k]),  act[k][0]);
         chk($sformatf("d%0d_vmax", k),  32'(vmax_o[k]),  act[k][1]);
         chk($sformatf("d%0d_hsync", k), 32'(hsync_o[k]), act[k][2]);
         chk($sformatf("d%0d_vsync", k), 32'(vsync_o[k]), act[k][3]);
         chk($sformatf("d%0d_hleft", k), 32'(hl_o[k]),    act[k][4]);
         chk($sformatf("d%0d_hright", k),32'(hr_o[k]),    act[k][5]);
         chk($sformatf("d%0d_vleft", k), 32'(vl_o[k]),    act[k][6]);
         chk($sformatf("d%0d_vright", k),32'(vr_o[k]),    act[k][7]);
      end
   endtask

   // Inputs change at posedge+1 and are sampled at the next posedge.
   task automatic tick();
      @(posedge Clk);
      model_step(0);
      model_step(1);
      #1;
      check_all();
   endtask

   task automatic wr(input int k, input int off, input int d);
      valid_i[k] = 1'b1;
      addr_i[k]  = 16'(16 + off);
      data_i[k]  = 16'(d);
      tick();
      valid_i[k] = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset(0);
      model_reset(1);
      #1 check_all();
      tick();
      tick();
      rst_n = 1'b1;
      #1 check_all();
      chk("rst_load_after_release", 32'(load_o[1]), 32'd1);
   endtask

   int custom_vals [8] = '{400, 300, 10, 2, 20, 30, 5, 6};

   initial begin
      for (int k = 0; k < 2; k++) begin
         valid_i[k] = 1'b0; addr_i[k] = '0; data_i[k] = '0; fe_i[k] = 1'b0;
      end
      rst_n = 1'b0;
      model_reset(0);
      model_reset(1);

      // 1: reset state and release
      tick();
      chk("t1_ready_in_reset", 32'(ready_o[0]), 32'd0);
      do_reset();
      tick();
      chk("t1_ready_after", 32'(ready_o[0]), 32'd1);
      chk("t1_hmax_p0", 32'(hmax_o[1]), 32'd800);

      // 2: immediate apply of 1024x768
      wr(0, 0, 2);
      chk("t2_hmax", 32'(hmax_o[0]), 32'd1344);
      chk("t2_vmax", 32'(vmax_o[0]), 32'd806);
      chk("t2_load", 32'(load_o[0]), 32'd1);
      tick();
      chk("t2_ready_back", 32'(ready_o[0]), 32'd1);

      // 3: deferred apply; Frame_end in the acceptance cycle is ignored
      valid_i[1] = 1'b1; addr_i[1] = 16'd16; data_i[1] = 16'd1; fe_i[1] = 1'b1;
      tick();
      fe_i[1] = 1'b0; addr_i[1] = 16'd19; data_i[1] = 16'd77;
      repeat (20) tick();
      chk("t3_not_applied", 32'(hmax_o[1]), 32'd800);
      valid_i[1] = 1'b0; fe_i[1] = 1'b1;
      tick();
      fe_i[1] = 1'b0;
      chk("t3_hmax", 32'(hmax_o[1]), 32'd1056);
      chk("t3_load", 32'(load_o[1]), 32'd1);
      tick();

      // 4: custom mode, then an invalid custom set
      for (int i = 0; i < 8; i++) wr(0, i + 1, custom_vals[i]);
      wr(0, 0, 3);
      chk("t4_mode", 32'(mode_o[0]), 32'd3);
      chk("t4_hleft", 32'(hl_o[0]), 32'd20);
      tick();
      wr(0, 1, 50);
      wr(0, 0, 3);
      tick();
      chk("t4_hmax_kept", 32'(hmax_o[0]), 32'd400);

      // 5: snapshot immune to blocked writes while pending; bad mode value
      for (int i = 0; i < 8; i++) wr(1, i + 1, custom_vals[i]);
      wr(1, 0, 3);
      wr(1, 3, 99);
      tick();
      fe_i[1] = 1'b1;
      tick();
      fe_i[1] = 1'b0;
      chk("t5_hsync", 32'(hsync_o[1]), 32'd10);
      tick();
      wr(1, 0, 7);
      chk("t5_err", 32'(err_o[1]), 32'd1);
      chk("t5_no_load", 32'(load_o[1]), 32'd0);

      // 6: reset while pending discards the pending mode
      wr(1, 0, 2);
      do_reset();
      tick();
      fe_i[1] = 1'b1;
      tick();
      fe_i[1] = 1'b0;
      chk("t6_mode_p0", 32'(mode_o[1]), 32'd0);
      chk("t6_hmax_p0", 32'(hmax_o[1]), 32'd800);

      // Randomized traffic on both instances
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < 2; k++) begin
            int r;
            r = int'($urandom_range(0, 11));
            valid_i[k] = ($urandom_range(0, 1) == 1);
            fe_i[k]    = ($urandom_range(0, 7) == 0);
            if (r <= 9)       addr_i[k] = 16'(16 + r);
            else if (r == 10) addr_i[k] = 16'h000F;
            else              addr_i[k] = 16'($urandom);
            if (r == 0)                       data_i[k] = 16'($urandom_range(0, 5));
            else if ($urandom_range(0, 9) == 0) data_i[k] = 16'($urandom);
            else if (r <= 2)                  data_i[k] = 16'($urandom_range(0, 2047));
            else                              data_i[k] = 16'($urandom_range(0, 120));
         end
         tick();
      end
      valid_i[0] = 1'b0; valid_i[1] = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
